montacarga_planta: RTL and testbench
====================================

Name: montacarga_planta

Overview:
Synthesisable model of the freight-elevator shaft: the plant end of the controller's MOTOR/FC interface.
- Consumes the 2-bit MOTOR command and integrates car position with a clock prescaler.
- Drives the FC1..FC3 floor limit switches back to the controller.
- Used on the FPGA board in place of real hardware and in closed-loop simulation.
- Detects illegal motor commands and mechanical overtravel.

Parameters:
TICKS_PER_STEP, 50000, CLK cycles per one position step while moving (>=2).
STEPS_PER_FLOOR, 16, position steps between adjacent floors (>=2).
POS_W, 6, width of POS; must hold 2*STEPS_PER_FLOOR.
INIT_POS, 0, POS value loaded on reset (0 = floor 1).

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET_N  in  1  synchronous, active-low reset
MOTOR  in  2  01 = up, 10 = down, 00 = stop, 11 = illegal
FC1  out  1  high while POS == 0
FC2  out  1  high while POS == STEPS_PER_FLOOR
FC3  out  1  high while POS == 2*STEPS_PER_FLOOR
POS  out  POS_W  car position in steps, 0 = floor 1
MOVING  out  1  high in UP or DOWN state
FAULT  out  1  sticky fault flag
FAULT_CODE  out  2  00 none, 01 illegal MOTOR=11, 10 overtravel, 11 direct reversal

Behaviour:
- Reset: RESET_N low at a rising edge gives:
  - state = IDLE, POS = INIT_POS, prescaler = 0
  - MOVING = 0, FAULT = 0, FAULT_CODE = 00
  - FC outputs follow the decode of INIT_POS.
  - Reset has priority over everything, including mid-move and FAULT.
- FC1..FC3: pure decode of the POS register. No extra latency, so they change in the same cycle as POS. All three are 0 between floors.
- States: IDLE, UP, DOWN, FLT. MOTOR is sampled every edge.
- IDLE:
  - MOTOR = 01 -> UP; MOTOR = 10 -> DOWN.
  - MOTOR = 11 -> FLT, code 01.
  - Prescaler is held at 0 in IDLE.
- UP:
  - Prescaler increments each edge.
  - At the edge where prescaler == TICKS_PER_STEP-1: prescaler <= 0 and POS <= POS+1.
  - First step lands exactly TICKS_PER_STEP edges after the IDLE->UP edge.
- DOWN: as UP, with POS <= POS-1.
- Stop: MOTOR = 00 in UP/DOWN -> IDLE at that edge.
  - Prescaler cleared, partial step discarded, POS retained.
  - POS may stop between floors.
- Reversal: MOTOR = 10 in UP or 01 in DOWN (no intervening 00) -> FLT, code 11.
- Illegal command: MOTOR = 11 in any non-FLT state -> FLT, code 01.
- Overtravel: a step that would take POS above 2*STEPS_PER_FLOOR or below 0 is not applied. Instead -> FLT, code 10, and POS stays at the end value.
- Priority when several conditions hold on one edge: reset > illegal(01) > reversal(11) > overtravel(10) > step.
- FLT:
  - POS frozen, MOVING = 0, FAULT = 1, FAULT_CODE held.
  - MOTOR is ignored; exit only via reset.
- No arithmetic wraps: POS never leaves 0..2*STEPS_PER_FLOOR.
- Outputs POS, MOVING, FAULT, FAULT_CODE are registered.

Test Plan (TICKS_PER_STEP=4, STEPS_PER_FLOOR=3, INIT_POS=0):
- Reset then MOTOR=01 held at edge k:
  - MOVING=1 from edge k.
  - POS=1 at k+4, FC1 falls at k+4.
  - POS=3 and FC2=1 at k+12.
  - MOTOR=00 at the next edge -> MOVING=0, POS stays 3.
- From POS=6 (FC3=1), MOTOR=10 for 24 edges:
  - POS steps 5,4,...,0 every 4 edges.
  - FC2 high only while POS=3, FC1 rises at POS=0.
- Up move interrupted: MOTOR=01 for 6 edges then 00:
  - POS=1, all FC=0, MOTOR=01 again -> next step 4 edges after restart (partial step discarded).
- At POS=6 hold MOTOR=01: at edge k+4 POS stays 6, FAULT=1, FAULT_CODE=10, MOVING=0. Later MOTOR=10 -> POS unchanged.
- Faults on illegal command and reversal:
  - While UP apply MOTOR=10 directly -> FAULT_CODE=11 next edge.
  - From a separate reset, MOTOR=11 -> FAULT_CODE=01.
- Reset mid-move: RESET_N=0 at POS=2 during UP -> next edge POS=0, FC1=1, FAULT=0, MOVING=0. Also clears a prior FLT.

Source files
------------

// File: rtl/montacarga_planta_if.sv
// Plant-side bundle between the elevator controller and the shaft model:
// the motor command going down and the limit switches / status coming back.
interface montacarga_planta_if #(
    parameter int POS_W = 6
);
    logic [1:0]       MOTOR;
    logic             FC1;
    logic             FC2;
    logic             FC3;
    logic [POS_W-1:0] POS;
    logic             MOVING;
    logic             FAULT;
    logic [1:0]       FAULT_CODE;

    modport master (
        output MOTOR,
        input  FC1, FC2, FC3, POS, MOVING, FAULT, FAULT_CODE
    );

    modport slave (
        input  MOTOR,
        output FC1, FC2, FC3, POS, MOVING, FAULT, FAULT_CODE
    );
endinterface

// File: rtl/montacarga_planta.sv
// Freight-elevator shaft model: integrates car position from the MOTOR command,
// decodes floor limit switches and latches illegal-command / overtravel faults.
module montacarga_planta #(
    parameter int TICKS_PER_STEP  = 50000,
    parameter int STEPS_PER_FLOOR = 16,
    parameter int POS_W           = 6,
    parameter int INIT_POS        = 0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    montacarga_planta_if.slave    bus
);

    localparam int PRE_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_STEP - 1);

    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_FL1  = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] POS_FL2  = POS_W'(STEPS_PER_FLOOR);
    localparam logic [POS_W-1:0] POS_FL3  = POS_W'(2 * STEPS_PER_FLOOR);
    localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_UP   = 2'b01;
    localparam logic [1:0] MOT_DN   = 2'b10;
    localparam logic [1:0] MOT_ILL  = 2'b11;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_ILL  = 2'b01;
    localparam logic [1:0] CODE_OVT  = 2'b10;
    localparam logic [1:0] CODE_REV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_FLT  = 2'b11
    } state_t;

    state_t           state_q,  state_d;
    logic [PRE_W-1:0] presc_q,  presc_d;
    logic [POS_W-1:0] pos_q,    pos_d;
    logic             moving_q, moving_d;
    logic             fault_q,  fault_d;
    logic [1:0]       code_q,   code_d;

    logic             step_due_s;
    logic [POS_W-1:0] pos_inc_s;
    logic [POS_W-1:0] pos_dec_s;

    assign step_due_s = (presc_q == PRE_LAST);
    assign pos_inc_s  = pos_q + POS_ONE;
    assign pos_dec_s  = pos_q - POS_ONE;

    // Next-state, prescaler and position update; fault causes checked in priority order.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        pos_d   = pos_q;
        code_d  = code_q;

        case (state_q)
            ST_IDLE: begin
                presc_d = PRE_ZERO;
                if (bus.MOTOR == MOT_ILL) begin
                    state_d = ST_FLT;
                    code_d  = CODE_ILL;
                end else if (bus.MOTOR == MOT_UP) begin
                    state_d = ST_UP;
                end else if (bus.MOTOR == MOT_DN) begin
                    state_d = ST_DOWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_UP: begin
                if (bus.MOTOR == MOT_ILL) begin
                    state_d = ST_FLT;
                    code_d  = CODE_ILL;
                    presc_d = PRE_ZERO;
                end else if (bus.MOTOR == MOT_DN) begin
                    state_d = ST_FLT;
                    code_d  = CODE_REV;
                    presc_d = PRE_ZERO;
                end else if (bus.MOTOR == MOT_STOP) begin
                    state_d = ST_IDLE;
                    presc_d = PRE_ZERO;
                end else if (step_due_s) begin
                    presc_d = PRE_ZERO;
                    if (pos_q == POS_FL3) begin
                        state_d = ST_FLT;
                        code_d  = CODE_OVT;
                    end else begin
                        pos_d = pos_inc_s;
                    end
                end else begin
                    presc_d = presc_q + PRE_ONE;
                end
            end

            ST_DOWN: begin
                if (bus.MOTOR == MOT_ILL) begin
                    state_d = ST_FLT;
                    code_d  = CODE_ILL;
                    presc_d = PRE_ZERO;
                end else if (bus.MOTOR == MOT_UP) begin
                    state_d = ST_FLT;
                    code_d  = CODE_REV;
                    presc_d = PRE_ZERO;
                end else if (bus.MOTOR == MOT_STOP) begin
                    state_d = ST_IDLE;
                    presc_d = PRE_ZERO;
                end else if (step_due_s) begin
                    presc_d = PRE_ZERO;
                    if (pos_q == POS_FL1) begin
                        state_d = ST_FLT;
                        code_d  = CODE_OVT;
                    end else begin
                        pos_d = pos_dec_s;
                    end
                end else begin
                    presc_d = presc_q + PRE_ONE;
                end
            end

            ST_FLT: begin
                // Latched until reset; the motor command is deliberately ignored.
                presc_d = PRE_ZERO;
            end

            default: begin
                state_d = ST_FLT;
                code_d  = CODE_ILL;
                presc_d = PRE_ZERO;
            end
        endcase

        moving_d = (state_d == ST_UP) || (state_d == ST_DOWN);
        fault_d  = (state_d == ST_FLT);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            presc_q  <= PRE_ZERO;
            pos_q    <= POS_INIT;
            moving_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= CODE_NONE;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            pos_q    <= pos_d;
            moving_q <= moving_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
        end
    end

    assign bus.POS        = pos_q;
    assign bus.MOVING     = moving_q;
    assign bus.FAULT      = fault_q;
    assign bus.FAULT_CODE = code_q;
    assign bus.FC1        = (pos_q == POS_FL1);
    assign bus.FC2        = (pos_q == POS_FL2);
    assign bus.FC3        = (pos_q == POS_FL3);

endmodule

// File: tb/tb_montacarga_planta.sv
// Self-checking bench for montacarga_planta: directed scenarios from the shaft
// behaviour plus a randomized closed-loop run against an edge-counting model.
module tb_montacarga_planta;

    localparam int T    = 4;
    localparam int S    = 3;
    localparam int PW   = 6;
    localparam int INIT = 0;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLK = ~CLK;

    montacarga_planta_if #(.POS_W(PW)) bus ();

    montacarga_planta #(
        .TICKS_PER_STEP  (T),
        .STEPS_PER_FLOOR (S),
        .POS_W           (PW),
        .INIT_POS        (INIT)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Model: direction of travel, edges spent moving since the last step/start.
    int m_pos   = INIT;
    int m_dir   = 0;
    int m_cnt   = 0;
    int m_code  = 0;
    bit m_fault = 1'b0;

    function automatic void model_step(input logic [1:0] motor, input logic rstn);
        int want;
        int np;
        want = (motor == 2'b01) ? 1 : ((motor == 2'b10) ? -1 : 0);
        if (!rstn) begin
            m_pos = INIT; m_dir = 0; m_cnt = 0; m_code = 0; m_fault = 1'b0;
        end else if (m_fault) begin
            m_dir = 0;
        end else if (motor == 2'b11) begin
            m_fault = 1'b1; m_code = 1; m_dir = 0;
        end else if (m_dir != 0 && want != 0 && want != m_dir) begin
            m_fault = 1'b1; m_code = 3; m_dir = 0;
        end else if (want == 0) begin
            m_dir = 0; m_cnt = 0;
        end else if (m_dir == 0) begin
            m_dir = want; m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == T) begin
                m_cnt = 0;
                np = m_pos + m_dir;
                if (np < 0 || np > 2 * S) begin
                    m_fault = 1'b1; m_code = 2; m_dir = 0;
                end else begin
                    m_pos = np;
                end
            end
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [PW-1:0] p;
        logic [1:0]    c;
        p = PW'(m_pos);
        c = 2'(m_code);
        return {(m_pos == 0), (m_pos == S), (m_pos == 2 * S), p,
                (m_dir != 0) && !m_fault, m_fault, c};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {bus.FC1, bus.FC2, bus.FC3, bus.POS, bus.MOVING, bus.FAULT, bus.FAULT_CODE};
    endfunction

    task automatic tick(input logic [1:0] motor, input logic rstn);
        bus.MOTOR = motor;
        RESET_N   = rstn;
        @(posedge CLK);
        model_step(motor, rstn);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(2'($urandom_range(0, 3)), 1'b0);
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_run++;
        if ({bus.FC1, bus.POS, bus.MOVING, bus.FAULT, bus.FAULT_CODE} !== {1'b1, 6'd0, 1'b0, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_const: got %b required 1_000000_0_0_00",
                     {bus.FC1, bus.POS, bus.MOVING, bus.FAULT, bus.FAULT_CODE});
        end
    endtask

    task automatic test_up_move();
        tick(2'b00, 1'b0);
        for (int i = 0; i <= 12; i++) begin
            tick(2'b01, 1'b1);
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL up_move[k+%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 4) begin
                n_run++;
                if ({bus.POS, bus.FC1, bus.MOVING} !== {6'd1, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL up_first_step: got pos=%0d fc1=%b mv=%b required 1 0 1",
                             bus.POS, bus.FC1, bus.MOVING);
                end
            end
        end
        n_run++;
        if ({bus.POS, bus.FC2} !== {6'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL up_floor2: got pos=%0d fc2=%b required 3 1", bus.POS, bus.FC2);
        end
        tick(2'b00, 1'b1);
        n_run++;
        if ({bus.POS, bus.MOVING} !== {6'd3, 1'b0} || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL up_stop: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_down_full();
        tick(2'b00, 1'b0);
        for (int i = 0; i <= 24; i++) tick(2'b01, 1'b1);
        tick(2'b00, 1'b1);
        n_run++;
        if ({bus.POS, bus.FC3} !== {6'd6, 1'b1}) begin
            n_fail++;
            $display("FAIL down_start: got pos=%0d fc3=%b required 6 1", bus.POS, bus.FC3);
        end
        for (int i = 0; i <= 24; i++) begin
            tick(2'b10, 1'b1);
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL down_move[k+%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_run++;
        if ({bus.POS, bus.FC1, bus.FAULT} !== {6'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL down_floor1: got pos=%0d fc1=%b flt=%b required 0 1 0",
                     bus.POS, bus.FC1, bus.FAULT);
        end
    endtask

    task automatic test_partial_step();
        tick(2'b00, 1'b0);
        for (int i = 0; i < 6; i++) tick(2'b01, 1'b1);
        tick(2'b00, 1'b1);
        n_run++;
        if ({bus.POS, bus.FC1, bus.FC2, bus.FC3} !== {6'd1, 3'b000}) begin
            n_fail++;
            $display("FAIL partial_stop: got pos=%0d fc=%b%b%b required 1 000",
                     bus.POS, bus.FC1, bus.FC2, bus.FC3);
        end
        for (int i = 0; i <= 4; i++) begin
            tick(2'b01, 1'b1);
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL partial_restart[k+%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_run++;
        if (bus.POS !== 6'd2) begin
            n_fail++;
            $display("FAIL partial_discard: got pos=%0d required 2", bus.POS);
        end
    endtask

    task automatic test_overtravel();
        tick(2'b00, 1'b0);
        for (int i = 0; i <= 24; i++) tick(2'b01, 1'b1);
        for (int i = 0; i < 4; i++) tick(2'b01, 1'b1);
        n_run++;
        if ({bus.POS, bus.FAULT, bus.FAULT_CODE, bus.MOVING} !== {6'd6, 1'b1, 2'b10, 1'b0}) begin
            n_fail++;
            $display("FAIL overtravel_top: got %h expected pos6 flt1 code10 mv0", obs_vec());
        end
        for (int i = 0; i < 6; i++) tick(2'b10, 1'b1);
        n_run++;
        if (obs_vec() !== exp_vec() || bus.POS !== 6'd6) begin
            n_fail++;
            $display("FAIL overtravel_frozen: got %h expected %h", obs_vec(), exp_vec());
        end
        tick(2'b00, 1'b0);
        for (int i = 0; i <= 4; i++) tick(2'b10, 1'b1);
        n_run++;
        if ({bus.POS, bus.FAULT, bus.FAULT_CODE} !== {6'd0, 1'b1, 2'b10}) begin
            n_fail++;
            $display("FAIL overtravel_bottom: got %h expected pos0 flt1 code10", obs_vec());
        end
    endtask

    task automatic test_illegal_reversal();
        tick(2'b00, 1'b0);
        tick(2'b01, 1'b1);
        tick(2'b01, 1'b1);
        tick(2'b10, 1'b1);
        n_run++;
        if ({bus.FAULT, bus.FAULT_CODE, bus.MOVING} !== {1'b1, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL reversal: got %h expected flt1 code11 mv0", obs_vec());
        end
        tick(2'b00, 1'b1);
        tick(2'b01, 1'b1);
        n_run++;
        if (obs_vec() !== exp_vec() || bus.FAULT_CODE !== 2'b11) begin
            n_fail++;
            $display("FAIL reversal_sticky: got %h expected %h", obs_vec(), exp_vec());
        end
        tick(2'b00, 1'b0);
        tick(2'b11, 1'b1);
        n_run++;
        if ({bus.FAULT, bus.FAULT_CODE} !== {1'b1, 2'b01}) begin
            n_fail++;
            $display("FAIL illegal_idle: got %h expected flt1 code01", obs_vec());
        end
        tick(2'b00, 1'b0);
        tick(2'b10, 1'b1);
        tick(2'b11, 1'b1);
        n_run++;
        if ({bus.FAULT, bus.FAULT_CODE} !== {1'b1, 2'b01}) begin
            n_fail++;
            $display("FAIL illegal_moving: got %h expected flt1 code01", obs_vec());
        end
    endtask

    task automatic test_reset_mid_move();
        tick(2'b00, 1'b0);
        for (int i = 0; i <= 8; i++) tick(2'b01, 1'b1);
        n_run++;
        if (bus.POS !== 6'd2) begin
            n_fail++;
            $display("FAIL midmove_pre: got pos=%0d required 2", bus.POS);
        end
        tick(2'b01, 1'b0);
        n_run++;
        if ({bus.POS, bus.FC1, bus.FAULT, bus.MOVING} !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midmove_reset: got %h expected pos0 fc1 flt0 mv0", obs_vec());
        end
        tick(2'b11, 1'b1);
        tick(2'b00, 1'b0);
        n_run++;
        if ({bus.FAULT, bus.FAULT_CODE} !== {1'b0, 2'b00} || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fault_reset: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [1:0] motor;
        logic       rstn;
        motor = 2'b00;
        tick(2'b00, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 12) begin
                motor = ($urandom_range(0, 49) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end
            rstn = !(($urandom_range(0, 199) == 0) || (m_fault && $urandom_range(0, 9) == 0));
            tick(motor, rstn);
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d] motor=%b rstn=%b: got %h expected %h",
                         i, motor, rstn, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.MOTOR = 2'b00;
        test_reset();
        test_up_move();
        test_down_full();
        test_partial_step();
        test_overtravel();
        test_illegal_reversal();
        test_reset_mid_move();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
